// File: rtl/prog_mod_cnt_pkg.sv
// Shared constants for the programmable modulo counter and its cascades
// (direction encodings, 50 MHz clock timing, default geometry).
package prog_mod_cnt_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // 50 MHz reference clock
    localparam int unsigned TCK_NS      = 20;
    localparam logic [31:0] ONE_SEC_NUM = 32'd50000000;

    localparam int unsigned DEF_DIV_W = 32;
    localparam int unsigned DEF_CNT_W = 6;
    localparam int unsigned DEF_MOD   = 60;

endpackage

// File: rtl/prog_mod_cnt_tick_gen.sv
// Tick divider: counts enabled cycles and flags the terminal cycle of each
// num-cycle period; clr restarts the period.
module tick_gen
    import prog_mod_cnt_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] num,
    output logic             term
);

    logic [DIV_W-1:0] div_cnt;

    // >= so that lowering num mid-period terminates on the next enabled edge
    always_comb begin
        term = 1'b0;
        if (en) begin
            term = (num <= DIV_W'(1)) || (div_cnt >= (num - DIV_W'(1)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt <= '0;
        end else if (term) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/prog_mod_cnt.sv
// Programmable tick generator plus modulo-MOD up/down counter with load;
// carry pulses on wrap and is meant to drive the next stage's en.
module prog_mod_cnt
    import prog_mod_cnt_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned MOD   = DEF_MOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] num,
    input  logic             up_dn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] out,
    output logic             tick,
    output logic             carry
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MOD - 1);

    logic             term;
    logic [CNT_W-1:0] load_clamped;
    logic [CNT_W-1:0] next_out;
    logic             next_wrap;

    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .num  (num),
        .term (term)
    );

    // Load clamp and wrap-around successor for the current direction
    always_comb begin
        load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        next_out     = out;
        next_wrap    = 1'b0;
        if (up_dn == CNT_UP) begin
            next_wrap = (out == MAX_VAL);
            next_out  = next_wrap ? '0 : out + CNT_W'(1);
        end else begin
            next_wrap = (out == '0);
            next_out  = next_wrap ? MAX_VAL : out - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            tick  <= 1'b0;
            carry <= 1'b0;
        end else if (load) begin
            out   <= load_clamped;
            tick  <= 1'b0;
            carry <= 1'b0;
        end else if (term) begin
            out   <= next_out;
            tick  <= 1'b1;
            carry <= next_wrap;
        end else begin
            tick  <= 1'b0;
            carry <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_mod_cnt.sv
// Self-checking bench for prog_mod_cnt: cycle-level reference model plus
// directed scenarios with hand-computed checkpoints.
module tb_prog_mod_cnt;
    import prog_mod_cnt_pkg::*;

    localparam int unsigned DIV_W = 32;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned MOD   = 60;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [DIV_W-1:0] num = '0;
    logic             up_dn = CNT_UP;
    logic             load = 1'b0;
    logic [CNT_W-1:0] load_val = '0;
    logic [CNT_W-1:0] out;
    logic             tick;
    logic             carry;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference state: count value and enabled cycles since the last period start
    int     m_out = 0;
    longint m_elapsed = 0;
    bit     m_tick = 0;
    bit     m_carry = 0;
    bit     m_valid = 0;

    prog_mod_cnt #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W),
        .MOD   (MOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .num      (num),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .tick     (tick),
        .carry    (carry)
    );

    always #(TCK_NS / 2) clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one tick per period of max(num,1) enabled cycles; modular step on tick
    always @(posedge clk) begin
        longint period;
        period = (num < 2) ? 1 : longint'(num);
        if (rst) begin
            m_out = 0; m_elapsed = 0; m_tick = 0; m_carry = 0; m_valid = 1;
        end else if (load) begin
            m_out = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
            m_elapsed = 0; m_tick = 0; m_carry = 0;
        end else if (en && (m_elapsed + 1 >= period)) begin
            m_carry = (up_dn == CNT_UP) ? (m_out == MOD - 1) : (m_out == 0);
            m_out = (up_dn == CNT_UP) ? (m_out + 1) % MOD : (m_out + MOD - 1) % MOD;
            m_elapsed = 0; m_tick = 1;
        end else begin
            if (en) m_elapsed++;
            m_tick = 0; m_carry = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_out", int'(out), m_out);
            check("model_tick", int'(tick), int'(m_tick));
            check("model_carry", int'(carry), int'(m_carry));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pin(input string name, input int e_out, input int e_tick, input int e_carry);
        check({name, "_out"}, int'(out), e_out);
        check({name, "_tick"}, int'(tick), e_tick);
        check({name, "_carry"}, int'(carry), e_carry);
    endtask

    initial begin
        @(negedge clk);
        // 1: up count, num=4, full wrap after 60 ticks
        rst = 1; en = 1; num = 4; up_dn = CNT_UP;
        cyc(1); pin("reset", 0, 0, 0);
        rst = 0;
        cyc(3); pin("t1_pre", 0, 0, 0);
        cyc(1); pin("t1_first", 1, 1, 0);
        cyc(1); pin("t1_pulse", 1, 0, 0);
        cyc(235); pin("t1_wrap", 0, 1, 1);
        cyc(1); pin("t1_after", 0, 0, 0);

        // 2: down count, num=2
        rst = 1; up_dn = CNT_DN; num = 2;
        cyc(1); rst = 0;
        cyc(2); pin("t2_wrap", 59, 1, 1);
        cyc(2); pin("t2_next", 58, 1, 0);

        // 3: load mid-period restarts the divider
        up_dn = CNT_UP; num = 4; load = 1; load_val = 10;
        cyc(1); load = 0;
        cyc(2);
        load = 1; load_val = 25;
        cyc(1); pin("t3_load", 25, 0, 0);
        load = 0;
        cyc(3); pin("t3_wait", 25, 0, 0);
        cyc(1); pin("t3_tick", 26, 1, 0);

        // 4: out-of-range load clamps to MOD-1, then wraps up
        load = 1; load_val = 63;
        cyc(1); pin("t4_clamp", 59, 0, 0);
        load = 0; num = 1;
        cyc(1); pin("t4_wrap", 0, 1, 1);

        // 5: num=0/1 tick every cycle; en=0 freezes divider and count
        num = 0;
        cyc(3); pin("t5_num0", 3, 1, 0);
        num = 1;
        cyc(2); pin("t5_num1", 5, 1, 0);
        num = 4; load = 1; load_val = 0;
        cyc(1); load = 0;
        cyc(2);
        en = 0;
        cyc(1); pin("t5_frz", 0, 0, 0);
        cyc(4); pin("t5_frz_end", 0, 0, 0);
        en = 1;
        cyc(1); pin("t5_resume", 0, 0, 0);
        cyc(1); pin("t5_tick", 1, 1, 0);

        // load on a terminal edge wins, no tick
        num = 1; load = 1; load_val = 5;
        cyc(1); pin("ld_vs_term", 5, 0, 0);
        load = 0;

        // 6: lowering num below elapsed count terminates immediately
        num = 10; load = 1; load_val = 0;
        cyc(1); load = 0;
        cyc(7); pin("t6_mid", 0, 0, 0);
        num = 3;
        cyc(1); pin("t6_early", 1, 1, 0);
        load = 1; load_val = 37;
        cyc(1); load = 0; num = 1;
        cyc(1); pin("t6_pre_rst", 38, 1, 0);
        rst = 1;
        cyc(1); pin("t6_rst", 0, 0, 0);
        rst = 0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
